chunked_addsub: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/chunked_addsub_adder_chunk.sv | 37 +++
 rtl/full_adder.sv | 19 +
 rtl/chunked_addsub.sv | 125 ++++++++++++
 tb/tb_chunked_addsub.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types for the chunked add/subtract unit.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
    } addsub_flags_t;

    // Chunk index counter width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_addsub_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Brief    : Combinational CHUNK-bit ripple adder built from full-adder cells.
// Revision : 1.0
// ============================================================================
module adder_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (w_carry[i]),
            .s_o (sum[i]),
            .c_o (w_carry[i+1])
        );
    end

    // Carry into the top bit; only meaningful for overflow on the last slice.
    assign cin_msb = w_carry[CHUNK-1];
    assign cout    = w_carry[CHUNK];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : 1-bit full-adder cell.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_addsub
// Brief    : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle, with flags.
// Revision : 1.0
// ============================================================================
module chunked_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_idxw   = idx_width(c_nchunk);
    localparam logic [c_idxw-1:0] c_last_idx = c_idxw'(c_nchunk - 1);

    addsub_state_t     state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [c_idxw-1:0] idx_q;
    logic [WIDTH-1:0]  sum_q;
    logic [WIDTH-1:0]  sum_d;
    addsub_flags_t     flags_q;

    logic [CHUNK-1:0]  w_slice_a;
    logic [CHUNK-1:0]  w_slice_b;
    logic [CHUNK-1:0]  w_slice_sum;
    logic              w_slice_cout;
    logic              w_slice_cin_msb;
    logic              w_load;

    assign w_slice_a = a_q[idx_q*CHUNK +: CHUNK];
    assign w_slice_b = b_q[idx_q*CHUNK +: CHUNK];

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_adder_chunk (
        .a       (w_slice_a),
        .b       (w_slice_b),
        .cin     (carry_q),
        .sum     (w_slice_sum),
        .cout    (w_slice_cout),
        .cin_msb (w_slice_cin_msb)
    );

    always_comb begin
        sum_d                        = sum_q;
        sum_d[idx_q*CHUNK +: CHUNK]  = w_slice_sum;
    end

    // DONE hands the slot straight to a new operation when the result is taken.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            flags_q <= '0;
        end else if (w_load) begin
            // Subtraction is a + ~b + 1: invert b here, seed the carry with sub.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            state_q <= BUSY;
        end else begin
            case (state_q)
                BUSY: begin
                    sum_q   <= sum_d;
                    carry_q <= w_slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == c_last_idx) begin
                        flags_q.cout     <= w_slice_cout;
                        flags_q.overflow <= w_slice_cin_msb ^ w_slice_cout;
                        flags_q.zero     <= (sum_d == '0);
                        flags_q.negative <= sum_d[WIDTH-1];
                        state_q          <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule
`default_nettype wire

// File: tb/tb_chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_addsub
// Brief    : Self-checking bench for chunked_addsub (WIDTH=64, CHUNK=16).
// Revision : 1.0
// ============================================================================
module tb_chunked_addsub;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    chunked_addsub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    longint cyc  = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        longint           edge_n;
    } exp_t;

    exp_t q[$];

    // Reference result from plain wide arithmetic and sign rules.
    function automatic exp_t model(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                                   input logic es, input longint edge_n);
        exp_t             e;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        bb       = es ? ~eb : eb;
        full     = {1'b0, ea} + {1'b0, bb} + (WIDTH+1)'(es);
        e.sum    = full[WIDTH-1:0];
        e.cout   = full[WIDTH];
        e.ovf    = (ea[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != ea[WIDTH-1]);
        e.zero   = (e.sum == '0);
        e.neg    = e.sum[WIDTH-1];
        e.edge_n = edge_n;
        return e;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge rst_n) q.delete();

    // Track accepts and consumptions on the active edge (pre-edge values).
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(a, b, sub, cyc));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_sum", sum, 0);
            check("rst_flags", {cout, overflow, zero, negative}, 0);
        end else if (q.size() == 0) begin
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 1);
        end else begin
            check("valid_timing", out_valid, (cyc - q[0].edge_n) >= NCHUNK);
            if (out_valid) begin
                check("m_sum", sum, q[0].sum);
                check("m_cout", cout, q[0].cout);
                check("m_overflow", overflow, q[0].ovf);
                check("m_zero", zero, q[0].zero);
                check("m_negative", negative, q[0].neg);
                check("done_in_ready", in_ready, out_ready);
            end else begin
                check("busy_in_ready", in_ready, 0);
            end
        end
    end

    longint acc_cyc;

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts);
        bit got;
        got = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        sub = ts;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            fails++;
            tests++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom);
    endtask

    task automatic get_result(input string name, input logic [WIDTH-1:0] es, input logic ec,
                              input logic ev, input logic ez, input logic en, input bit consume);
        bit got;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            fails++;
            tests++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
        end else begin
            check({name, "_latency"}, 64'(cyc - acc_cyc), NCHUNK);
            check({name, "_sum"}, sum, es);
            check({name, "_flags"}, {cout, overflow, zero, negative}, {ec, ev, ez, en});
        end
        if (consume) begin
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        get_result("carry_cross", 64'h0000_0000_0001_0000, 0, 0, 0, 0, 1);

        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        get_result("pos_ovf", 64'h8000_0000_0000_0000, 0, 1, 0, 1, 1);

        do_op(64'd5, 64'd5, 1'b1);
        get_result("sub_zero", 64'h0, 1, 0, 1, 0, 1);

        do_op(64'd0, 64'd1, 1'b1);
        get_result("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 1);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        get_result("wrap", 64'h0, 1, 0, 1, 0, 1);

        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        get_result("neg_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 1);

        // Backpressure with a new operation waiting in DONE.
        do_op(64'h1234, 64'h1111, 1'b1);
        get_result("bp_first", 64'h0123, 1, 0, 0, 0, 0);
        #1;
        in_valid = 1'b1;
        a = 64'd2;
        b = 64'd3;
        sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_sum", sum, 64'h0123);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        get_result("bp_second", 64'd5, 0, 0, 0, 0, 1);

        // Reset in the second BUSY cycle.
        do_op(64'd100, 64'd1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 0);
        check("midrst_flags", {cout, overflow, zero, negative}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_quiet", out_valid, 0);

        do_op(64'd10, 64'd20, 1'b0);
        get_result("after_rst", 64'd30, 0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
